freq_sweep_tracker: RTL
=======================

Name: freq_sweep_tracker

Overview:
Parametrised successor to the SWIPT frequency-sweep block. It sweeps the drive frequency over a run-time configurable window and averages ADC deviation from mid-scale over N samples per point. It reports the frequency that maximises that deviation. Optional coarse-then-fine mode re-sweeps around the coarse optimum with a finer step. Sits between the SWIPT control FSM (start/enable) and the oscillator frequency register (freq_out).

Parameters:
FREQ_W, 20, frequency word width
ADC_W, 12, ADC sample width (unsigned, mid-scale 2^(ADC_W-1))
SETTLE_CYC, 200000, clk cycles ignored after each frequency change (2 ms @100 MHz)
AVG_LOG2, 4, log2 of valid samples averaged per point
FINE_SHIFT, 2, fine step = max(step >> FINE_SHIFT, 1)
PARK_FREQ, 20'h88B8, frequency driven out of reset (35 kHz)

Ports:
clk  in  1  clock
nrst  in  1  reset, synchronous, active-low
enable  in  1  SWIPT link alive; low aborts and idles the block
start  in  1  one-cycle request to begin a sweep; config latched on accepted start
mode  in  1  0 = single pass, 1 = coarse + fine
f_start  in  FREQ_W  first sweep point
f_stop  in  FREQ_W  upper bound (inclusive)
f_step  in  FREQ_W  coarse step
adc  in  ADC_W  ADC sample
adc_valid  in  1  sample strobe
freq_out  out  FREQ_W  frequency to oscillator
best_freq  out  FREQ_W  frequency of best metric so far
best_mag  out  ADC_W-1  best averaged metric
busy  out  1  sweep in progress
done  out  1  level; sweep complete, held until next start or enable low
err  out  1  level; last start had illegal config

Behaviour:
- Reset (nrst=0 at clk edge): state IDLE, freq_out=best_freq=PARK_FREQ, best_mag=0, busy=done=err=0, counters 0.
- enable=0 (non-reset): state→IDLE next edge, busy=done=0, freq_out<=best_freq, err held. Sweep progress is discarded.
- States: IDLE, SETTLE, MEASURE, EVAL, FINE_SETUP, DONE.
- IDLE/DONE + start (enable=1): latch config. If f_step==0 or f_start>f_stop: err=1, done=1, state DONE, freq_out unchanged. Otherwise err=0, done=0, busy=1, best_mag=0, best_freq=f_start, freq_out=f_start, settle counter=SETTLE_CYC, state SETTLE.
- start while busy: ignored.
- SETTLE: count down 1/cycle; samples ignored; at 0 → MEASURE with accumulator and sample count cleared.
- MEASURE: on each adc_valid, mag = (adc>=MID) ? adc-MID : MID-1-adc (width ADC_W-1). Accumulate into an (ADC_W-1+AVG_LOG2)-bit sum. After 2^AVG_LOG2 samples → EVAL.
- EVAL (1 cycle): avg = sum>>AVG_LOG2. If avg > best_mag (strict), best_mag=avg and best_freq=freq_out; ties keep the earlier point. next = freq_out+step, computed FREQ_W+1 wide. If the carry is set or next > current hi, the pass ends. Otherwise freq_out=next, reload settle, → SETTLE.
- Pass end: mode=0 or fine pass finished → DONE: freq_out=best_freq, busy=0, done=1. Coarse pass in mode=1 → FINE_SETUP.
- FINE_SETUP (1 cycle): lo = max(best_freq-f_step, f_start), with underflow clamped to f_start. hi = min(best_freq+f_step, f_stop), with overflow clamped to f_stop. step = max(f_step>>FINE_SHIFT, 1). freq_out=lo, → SETTLE. best_* retained from the coarse pass.
- Non-aligned stop: the last point is the largest f_start+k·step ≤ f_stop.
- Per-point latency: SETTLE_CYC + time to 2^AVG_LOG2 valids + 1 EVAL cycle + 1 cycle transition.

Decomposition:
- Package freq_sweep_pkg: state enum; mode enum (MODE_SINGLE, MODE_COARSE_FINE); function mid_scale(ADC_W); metric-width constant.
- Sub-module freq_sweep_mag_avg: mag computation, accumulator and sample counter, with clear/valid inputs and avg/ready outputs.

Test Plan:
1. SETTLE_CYC=4, AVG_LOG2=1, mode 0, sweep 100..130 step 10. adc=0x800 except 0xC00 at 120 → 4 points visited, best_freq=120, best_mag=0x400, freq_out=120, done=1, busy=0.
2. Same window, adc=0x000 at 110 and 0xFFF at 130, others 0x800 → both give mag 0x7FF; tie keeps first, so best_freq=110.
3. mode 1, sweep 100..130 step 8, FINE_SHIFT=2, mag=0x100-16·|f-122|. Coarse visits 100,108,116,124 (best 124, 0xE0). Fine sweeps 116..130 step 2 → best_freq=122, best_mag=0x100.
4. start with f_step=0 → next edge err=1, done=1, busy=0, freq_out=PARK_FREQ. Subsequent valid start clears err.
5. Drop enable during MEASURE of point 2 → next edge busy=0, done=0, freq_out=best so far. Re-raise and start → full sweep completes normally. nrst mid-sweep → all outputs at reset values.
6. Sweep 100..125 step 10 → last point 120. f_start=0xFFFF0, f_stop=0xFFFFF, step=0x20 → one point, carry ends pass, done=1. start pulsed while busy → no effect.

Source files
------------

// File: rtl/freq_sweep_pkg.sv
// freq_sweep_pkg: shared state/mode types and ADC helper functions for the sweep tracker.
package freq_sweep_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETTLE,
    ST_MEASURE,
    ST_EVAL,
    ST_FINE_SETUP,
    ST_DONE
  } state_t;

  typedef enum logic {
    MODE_SINGLE      = 1'b0,
    MODE_COARSE_FINE = 1'b1
  } mode_t;

  // Width of the deviation metric for an adc_w-bit unsigned sample.
  function automatic int unsigned metric_w(input int unsigned adc_w);
    return adc_w - 1;
  endfunction

  // Mid-scale code of an adc_w-bit unsigned sample.
  function automatic int unsigned mid_scale(input int unsigned adc_w);
    return 32'd1 << (adc_w - 1);
  endfunction

endpackage

// File: rtl/freq_sweep_mag_avg.sv
// freq_sweep_mag_avg: deviation-from-mid-scale magnitude, accumulated over 2^AVG_LOG2 samples.
//   clear : drop accumulator and sample count (wins over valid)
//   valid : sample strobe, ignored once ready
//   adc   : unsigned sample
//   avg   : accumulated magnitude >> AVG_LOG2
//   ready : 2^AVG_LOG2 samples collected
module freq_sweep_mag_avg
  import freq_sweep_pkg::*;
#(
  parameter int unsigned ADC_W    = 12,
  parameter int unsigned AVG_LOG2 = 4
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             clear,
  input  logic             valid,
  input  logic [ADC_W-1:0] adc,
  output logic [ADC_W-2:0] avg,
  output logic             ready
);

  localparam int unsigned MW    = metric_w(ADC_W);
  localparam int unsigned SUM_W = MW + AVG_LOG2;
  localparam int unsigned CNT_W = AVG_LOG2 + 1;
  localparam logic [ADC_W-1:0] MID = ADC_W'(mid_scale(ADC_W));

  logic [MW-1:0]    mag;
  logic [SUM_W-1:0] sum_q;
  logic [CNT_W-1:0] cnt_q;

  // MID is a power of two: adc-MID is the low bits, MID-1-adc their complement.
  always_comb begin
    mag = (adc >= MID) ? adc[MW-1:0] : ~adc[MW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      sum_q <= '0;
      cnt_q <= '0;
    end else if (valid && !ready) begin
      sum_q <= sum_q + SUM_W'(mag);
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    ready = cnt_q[CNT_W-1];
    avg   = MW'(sum_q >> AVG_LOG2);
  end

endmodule

// File: rtl/freq_sweep_tracker.sv
// freq_sweep_tracker: sweeps freq_out over [f_start, f_stop] and keeps the point with the
// largest averaged ADC deviation; optional fine re-sweep around the coarse optimum.
//   enable/start/mode/f_start/f_stop/f_step : control and sweep config (latched on start)
//   adc/adc_valid                           : sample stream
//   freq_out/best_freq/best_mag             : drive frequency and best point so far
//   busy/done/err                           : status levels
module freq_sweep_tracker
  import freq_sweep_pkg::*;
#(
  parameter int unsigned       FREQ_W     = 20,
  parameter int unsigned       ADC_W      = 12,
  parameter int unsigned       SETTLE_CYC = 200000,
  parameter int unsigned       AVG_LOG2   = 4,
  parameter int unsigned       FINE_SHIFT = 2,
  parameter logic [FREQ_W-1:0] PARK_FREQ  = 'h88B8
) (
  input  logic              clk,
  input  logic              nrst,
  input  logic              enable,
  input  logic              start,
  input  logic              mode,
  input  logic [FREQ_W-1:0] f_start,
  input  logic [FREQ_W-1:0] f_stop,
  input  logic [FREQ_W-1:0] f_step,
  input  logic [ADC_W-1:0]  adc,
  input  logic              adc_valid,
  output logic [FREQ_W-1:0] freq_out,
  output logic [FREQ_W-1:0] best_freq,
  output logic [ADC_W-2:0]  best_mag,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned SC_W = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC + 1) : 1;
  localparam logic [SC_W-1:0] SETTLE_LOAD = SC_W'(SETTLE_CYC);

  state_t state_q, state_d;
  mode_t  mode_q;

  logic [FREQ_W-1:0] freq_q, best_freq_q, hi_q, step_q;
  logic [FREQ_W-1:0] cfg_start_q, cfg_stop_q, cfg_step_q;
  logic [ADC_W-2:0]  best_mag_q;
  logic [SC_W-1:0]   settle_q;
  logic              err_q, fine_q;

  logic [ADC_W-2:0]  avg;
  logic              ready, avg_clear, avg_valid;

  logic              cfg_bad, better, pass_end, to_done;
  logic [FREQ_W-1:0] best_f_eval;
  logic [FREQ_W:0]   next_f, up_sum;
  logic [FREQ_W-1:0] dn_diff, lo_d, hi_d, step_shr, fstep_d;

  freq_sweep_mag_avg #(
    .ADC_W   (ADC_W),
    .AVG_LOG2(AVG_LOG2)
  ) u_mag_avg (
    .clk  (clk),
    .nrst (nrst),
    .clear(avg_clear),
    .valid(avg_valid),
    .adc  (adc),
    .avg  (avg),
    .ready(ready)
  );

  always_comb begin
    avg_clear = (state_q != ST_MEASURE) && (state_q != ST_EVAL);
    avg_valid = adc_valid && (state_q == ST_MEASURE);
  end

  always_comb begin
    cfg_bad     = (f_step == '0) || (f_start > f_stop);
    better      = avg > best_mag_q;
    best_f_eval = better ? freq_q : best_freq_q;
    next_f      = {1'b0, freq_q} + {1'b0, step_q};
    pass_end    = next_f[FREQ_W] || (next_f[FREQ_W-1:0] > hi_q);
    to_done     = (mode_q == MODE_SINGLE) || fine_q;
  end

  // Fine window: both ends clamped to the configured range, including wrap cases.
  always_comb begin
    dn_diff = best_freq_q - cfg_step_q;
    if ((best_freq_q < cfg_step_q) || (dn_diff < cfg_start_q)) lo_d = cfg_start_q;
    else                                                       lo_d = dn_diff;
    up_sum = {1'b0, best_freq_q} + {1'b0, cfg_step_q};
    if (up_sum[FREQ_W] || (up_sum[FREQ_W-1:0] > cfg_stop_q)) hi_d = cfg_stop_q;
    else                                                    hi_d = up_sum[FREQ_W-1:0];
    step_shr = cfg_step_q >> FINE_SHIFT;
    fstep_d  = (step_shr == '0) ? FREQ_W'(1) : step_shr;
  end

  always_ff @(posedge clk) begin
    if (!nrst) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (!enable) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: if (start) state_d = cfg_bad ? ST_DONE : ST_SETTLE;
        ST_SETTLE:        if (settle_q == '0) state_d = ST_MEASURE;
        ST_MEASURE:       if (ready) state_d = ST_EVAL;
        ST_EVAL: begin
          if (pass_end) state_d = to_done ? ST_DONE : ST_FINE_SETUP;
          else          state_d = ST_SETTLE;
        end
        ST_FINE_SETUP:    state_d = ST_SETTLE;
        default:          state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    busy = (state_q == ST_SETTLE) || (state_q == ST_MEASURE) ||
           (state_q == ST_EVAL)   || (state_q == ST_FINE_SETUP);
    done = (state_q == ST_DONE);
  end

  always_ff @(posedge clk) begin
    if (!nrst) begin
      freq_q      <= PARK_FREQ;
      best_freq_q <= PARK_FREQ;
      best_mag_q  <= '0;
      err_q       <= 1'b0;
      fine_q      <= 1'b0;
      mode_q      <= MODE_SINGLE;
      hi_q        <= '0;
      step_q      <= '0;
      cfg_start_q <= '0;
      cfg_stop_q  <= '0;
      cfg_step_q  <= '0;
      settle_q    <= '0;
    end else if (!enable) begin
      freq_q <= best_freq_q;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            if (cfg_bad) begin
              err_q <= 1'b1;
            end else begin
              err_q       <= 1'b0;
              cfg_start_q <= f_start;
              cfg_stop_q  <= f_stop;
              cfg_step_q  <= f_step;
              mode_q      <= mode_t'(mode);
              hi_q        <= f_stop;
              step_q      <= f_step;
              fine_q      <= 1'b0;
              best_mag_q  <= '0;
              best_freq_q <= f_start;
              freq_q      <= f_start;
              settle_q    <= SETTLE_LOAD;
            end
          end
        end
        ST_SETTLE: begin
          if (settle_q != '0) settle_q <= settle_q - SC_W'(1);
        end
        ST_EVAL: begin
          if (better) begin
            best_mag_q  <= avg;
            best_freq_q <= freq_q;
          end
          if (!pass_end) begin
            freq_q   <= next_f[FREQ_W-1:0];
            settle_q <= SETTLE_LOAD;
          end else if (to_done) begin
            freq_q <= best_f_eval;
          end
        end
        ST_FINE_SETUP: begin
          freq_q   <= lo_d;
          hi_q     <= hi_d;
          step_q   <= fstep_d;
          fine_q   <= 1'b1;
          settle_q <= SETTLE_LOAD;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    freq_out  = freq_q;
    best_freq = best_freq_q;
    best_mag  = best_mag_q;
    err       = err_q;
  end

endmodule
